spi_slave_param: RTL
====================

SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the payload width in bits (legal range 4..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, where 1 means payload bits are transferred MSB first and 0 means LSB first.
REQ-003 The block SHALL use the derived constant FRAME_W = DATA_W+2 for the command bits plus the payload.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: the asynchronous, active-low reset.
REQ-006 The block SHALL have port SS_n, input, 1 bit: slave select, active low.
REQ-007 The block SHALL have port MOSI, input, 1 bit: serial data in, sampled on clk.
REQ-008 The block SHALL have port MISO, output, 1 bit: serial data out, registered.
REQ-009 The block SHALL have port rx_data, output, FRAME_W bits: the received frame, with the command in [FRAME_W-1:FRAME_W-2] and the payload in [DATA_W-1:0].
REQ-010 The block SHALL have port rx_valid, output, 1 bit: a one-cycle pulse when rx_data is updated.
REQ-011 The block SHALL have port tx_data, input, DATA_W bits: read data to be shifted out.
REQ-012 The block SHALL have port tx_valid, input, 1 bit: a qualifier that loads tx_data.
REQ-013 The block SHALL have port frame_err, output, 1 bit: a one-cycle pulse on an aborted frame.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA and TX_SHIFT.
REQ-016 From IDLE, SS_n=0 SHALL move the FSM to CHK_CMD on the next cycle; otherwise it stays in IDLE.
REQ-017 In CHK_CMD, the MOSI sample SHALL be the first frame bit (command MSB), stored into shift bit FRAME_W-1.
REQ-018 From CHK_CMD, the next state SHALL be WRITE if MOSI=0, READ_ADD if MOSI=1 with rd_pend=0, and READ_DATA if MOSI=1 with rd_pend=1.
REQ-019 In WRITE, READ_ADD and READ_DATA, the block SHALL sample one bit per cycle while SS_n=0, until FRAME_W bits in total are captured.
REQ-020 The second frame bit SHALL always fill rx_data[FRAME_W-2].
REQ-021 Payload bits SHALL fill rx_data[DATA_W-1] downward when MSB_FIRST=1, and rx_data[0] upward when MSB_FIRST=0.
REQ-022 rx_data SHALL change only on frame completion, never mid-frame.
REQ-023 rx_valid SHALL pulse high for exactly one cycle, in the cycle after the FRAME_W-th bit is sampled, with rx_data valid in the same cycle.
REQ-024 In WRITE and READ_ADD, once the frame completes, the FSM SHALL stay in the same state, ignore MOSI and hold MISO=0 until SS_n=1.
REQ-025 A completed READ_ADD frame SHALL set rd_pend=1.
REQ-026 In READ_DATA, once the frame completes, the block SHALL wait for tx_valid.
REQ-027 In READ_DATA, the first cycle with tx_valid=1 SHALL load tx_data into the tx shift register, and the FSM SHALL enter TX_SHIFT on the next cycle.
REQ-028 tx_valid SHALL be ignored before the READ_DATA frame completes and while in TX_SHIFT.
REQ-029 In TX_SHIFT, MISO SHALL present one bit per cycle for DATA_W cycles, MSB first when MSB_FIRST=1 and LSB first otherwise.
REQ-030 After the last TX_SHIFT bit, the block SHALL clear rd_pend and drive MISO=0 until SS_n=1.
REQ-031 In every state other than TX_SHIFT, MISO SHALL be 0.
REQ-032 In any non-IDLE state, SS_n=1 SHALL move the FSM to IDLE on the next cycle.
REQ-033 A bit is not sampled in a cycle where SS_n=1, so a frame is incomplete if SS_n rises before its FRAME_W-th sample.
REQ-034 If SS_n rises before the frame completes, frame_err SHALL pulse one cycle, with no rx_valid, rx_data unchanged and rd_pend unchanged.
REQ-035 If SS_n rises during TX_SHIFT, frame_err SHALL pulse, and rd_pend SHALL stay 1 so that the read-data frame can be retried.
REQ-036 A READ_DATA frame whose second bit is 0 SHALL still complete with rx_valid, but SHALL skip the tx phase and leave rd_pend unchanged.
REQ-037 The bit counter SHALL be sized as clog2(FRAME_W)+1, and SHALL be reloaded on every entry to CHK_CMD.

Reset
REQ-038 While rst_n=0, regardless of clk, the block SHALL force state=IDLE, MISO=0, rx_data=0, rx_valid=0, frame_err=0, busy=0, rd_pend=0, and zero the counters and shift registers.
REQ-039 A reset asserted mid-frame SHALL discard the frame with no rx_valid and no frame_err.
REQ-040 After rst_n deasserts, the block SHALL begin sampling at the first rising clk edge.

Verification
REQ-041 Write-address: with DATA_W=8 and MSB_FIRST=1, send SS_n low then bits 00_10100101 -> rx_data=0x0A5, with rx_valid pulsing one cycle after the 10th bit and MISO=0 throughout.
REQ-042 Read cycle: send frame 10_00110011, then frame 11_xxxxxxxx, then tx_valid with tx_data=0xC3 -> MISO shows 1,1,0,0,0,0,1,1 on consecutive cycles, and rd_pend ends at 0.
REQ-043 LSB-first: with MSB_FIRST=0, send frame 01 then payload bits 1,0,0,0,0,0,0,0 -> rx_data=0x101.
REQ-044 Abort: raise SS_n after 6 bits of a write frame -> frame_err pulses once, with rx_valid=0 and rx_data holding its previous value.
REQ-045 Reset mid-TX: drop rst_n at the 3rd MISO bit -> MISO=0 and state=IDLE immediately, and the next 11-prefixed frame goes to READ_ADD because rd_pend=0.
REQ-046 Parameter sweep: with DATA_W=16, a write frame of 00 followed by 0xBEEF -> rx_data=0x0BEEF, with rx_valid pulsing after 18 samples.

Source files
------------

// File: rtl/spi_slave_param_if.sv
// SPI slave bus: serial pins plus the parallel receive/transmit handshake.
interface spi_slave_param_if #(
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned FRAME_W = DATA_W + 2;

  logic               SS_n;
  logic               MOSI;
  logic               MISO;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_valid;
  logic               frame_err;
  logic               busy;

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid, frame_err, busy
  );

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid, frame_err, busy
  );
endinterface

// File: rtl/spi_slave_param.sv
// Clk-sampled SPI slave: 2-bit command + DATA_W payload frames, with a
// two-frame read protocol (address frame, then data frame + tx shift-out).
module spi_slave_param #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  spi_slave_param_if.slave bus
);
  localparam int unsigned      FRAME_W     = DATA_W + 2;
  localparam int unsigned      CNT_W       = $clog2(FRAME_W) + 1;
  localparam logic [CNT_W-1:0] CNT_FRAME   = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_DATA    = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_TX_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4,
    TX_SHIFT  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic [DATA_W-1:0]  tx_sr_q, tx_sr_d;
  logic               rx_valid_q, rx_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               miso_q, miso_d;
  logic               rd_pend_q, rd_pend_d;
  logic               busy_q;
  logic [FRAME_W-1:0] sample;
  logic               frame_done;
  int                 bit_idx;

  function automatic logic tx_first(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? v[DATA_W-1] : v[0];
  endfunction

  function automatic logic [DATA_W-1:0] tx_next(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
  endfunction

  // Frame bit k lands at FRAME_W-1-k for the command (and MSB-first payload);
  // an LSB-first payload fills upward from bit 0.
  always_comb begin
    if (MSB_FIRST || (cnt_q < CNT_W'(2))) bit_idx = int'(FRAME_W) - 1 - int'(cnt_q);
    else                                   bit_idx = int'(cnt_q) - 2;
    sample = shift_q;
    for (int i = 0; i < int'(FRAME_W); i++) begin
      if (i == bit_idx) sample[i] = bus.MOSI;
    end
  end

  assign frame_done = (cnt_q == CNT_FRAME);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    tx_sr_d     = tx_sr_q;
    rd_pend_d   = rd_pend_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    miso_d      = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!bus.SS_n) state_d = CHK_CMD;
      end
      CHK_CMD: begin
        if (bus.SS_n) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else begin
          shift_d = sample;
          cnt_d   = CNT_W'(1);
          if (!bus.MOSI)      state_d = WRITE;
          else if (rd_pend_q) state_d = READ_DATA;
          else                state_d = READ_ADD;
        end
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (bus.SS_n) begin
          state_d     = IDLE;
          frame_err_d = !frame_done;
        end else if (!frame_done) begin
          shift_d = sample;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            rx_data_d  = sample;
            rx_valid_d = 1'b1;
            if (state_q == READ_ADD) rd_pend_d = 1'b1;
          end
        end else if ((state_q == READ_DATA) && shift_q[FRAME_W-2] && bus.tx_valid) begin
          // First MISO bit is registered together with the move to TX_SHIFT.
          tx_sr_d = tx_next(bus.tx_data);
          miso_d  = tx_first(bus.tx_data);
          cnt_d   = '0;
          state_d = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        if (bus.SS_n) begin
          state_d     = IDLE;
          frame_err_d = (cnt_q < CNT_DATA);
        end else if (cnt_q < CNT_DATA) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_TX_LAST) begin
            rd_pend_d = 1'b0;
          end else begin
            miso_d  = tx_first(tx_sr_q);
            tx_sr_d = tx_next(tx_sr_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      tx_sr_q     <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
      rd_pend_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      tx_sr_q     <= tx_sr_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
      rd_pend_q   <= rd_pend_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  assign bus.MISO      = miso_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;
endmodule
